// File: rtl/exu_seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH -> EXEC -> [MEM] -> WB with bus handshakes and state-write gating.
// Optional bus wait watchdog enabled by defining CTRL_BUS_TIMEOUT_EN; widths normally come from config.v.
module exu_seq_ctrl #(
  parameter int INST_NUM_WIDTH  = 8,
  parameter int INST_TYPE_WIDTH = 3,
  parameter int ISA_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES  = 255,
  parameter logic [INST_NUM_WIDTH-1:0]  INST_LW     = INST_NUM_WIDTH'(20),
  parameter logic [INST_NUM_WIDTH-1:0]  INST_SW     = INST_NUM_WIDTH'(21),
  parameter logic [INST_NUM_WIDTH-1:0]  INST_EBREAK = INST_NUM_WIDTH'(40),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_R      = INST_TYPE_WIDTH'(0),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_I      = INST_TYPE_WIDTH'(1),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_S      = INST_TYPE_WIDTH'(2),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_B      = INST_TYPE_WIDTH'(3),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_U      = INST_TYPE_WIDTH'(4),
  parameter logic [INST_TYPE_WIDTH-1:0] TYPE_J      = INST_TYPE_WIDTH'(5)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_NUM_WIDTH-1:0]  inst_num,
  input  logic [INST_TYPE_WIDTH-1:0] inst_type,
  input  logic                       pc_w_en_raw,
  output logic                       ifu_req_valid,
  input  logic                       ifu_req_ready,
  input  logic                       ifu_rsp_valid,
  output logic                       inst_w_en,
  output logic                       lsu_req_valid,
  input  logic                       lsu_req_ready,
  output logic                       lsu_req_wen,
  input  logic                       lsu_rsp_valid,
  output logic                       pc_w_en,
  output logic                       gpr_w_en,
  output logic                       halt,
  output logic                       illegal,
  output logic                       bus_err,
  output logic [ISA_WIDTH-1:0]       instret
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("exu_seq_ctrl: TIMEOUT_CYCLES must lie in 1..1023");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t state;

  logic type_ok;
  logic gpr_type;
  logic is_sw;
  logic is_mem;
  logic is_ebreak;
  logic timed_out;

  assign type_ok   = inst_type inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J};
  assign gpr_type  = inst_type inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J};
  assign is_sw     = (inst_num == INST_SW);
  assign is_mem    = (inst_num == INST_LW) || is_sw;
  assign is_ebreak = (inst_num == INST_EBREAK);

  // Write enables decode the live decoder/PC-unit inputs, but only in their owning state.
  assign inst_w_en   = (state == S_FWAIT) && ifu_rsp_valid;
  assign lsu_req_wen = (state == S_MEM) && is_sw;
  assign pc_w_en     = (state == S_WB) && pc_w_en_raw;
  assign gpr_w_en    = (state == S_WB) && gpr_type && !is_ebreak;

`ifdef CTRL_BUS_TIMEOUT_EN
  localparam logic [9:0] WAIT_LIMIT = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] wait_cnt;
  logic       in_wait;
  logic       wait_done;

  assign in_wait = state inside {S_FETCH, S_FWAIT, S_MEM, S_MWAIT};

  always_comb begin
    wait_done = 1'b0;
    case (state)
      S_FETCH: wait_done = ifu_req_ready;
      S_FWAIT: wait_done = ifu_rsp_valid;
      S_MEM:   wait_done = lsu_req_ready;
      S_MWAIT: wait_done = lsu_rsp_valid;
      default: wait_done = 1'b0;
    endcase
  end

  // A completing handshake in the limit cycle takes priority over the timeout.
  assign timed_out = in_wait && !wait_done && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (!in_wait || wait_done) wait_cnt <= '0;
      else                       wait_cnt <= wait_cnt + 10'd1;
      if (timed_out) bus_err <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // NOTE: every state register and registered output uses <= so all of them
  // sample the same pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      ifu_req_valid <= 1'b0;
      lsu_req_valid <= 1'b0;
      halt          <= 1'b0;
      illegal       <= 1'b0;
      instret       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state         <= S_FETCH;
          ifu_req_valid <= 1'b1;
        end
        S_FETCH: begin
          if (ifu_req_ready) begin
            state         <= S_FWAIT;
            ifu_req_valid <= 1'b0;
          end else if (timed_out) begin
            state         <= S_HALT;
            ifu_req_valid <= 1'b0;
            halt          <= 1'b1;
          end
        end
        S_FWAIT: begin
          if (ifu_rsp_valid) begin
            state <= S_EXEC;
          end else if (timed_out) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!type_ok) begin
            state   <= S_HALT;
            halt    <= 1'b1;
            illegal <= 1'b1;
          end else if (is_mem) begin
            state         <= S_MEM;
            lsu_req_valid <= 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (lsu_req_ready) begin
            state         <= S_MWAIT;
            lsu_req_valid <= 1'b0;
          end else if (timed_out) begin
            state         <= S_HALT;
            lsu_req_valid <= 1'b0;
            halt          <= 1'b1;
          end
        end
        S_MWAIT: begin
          if (lsu_rsp_valid) begin
            state <= S_WB;
          end else if (timed_out) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end
        end
        S_WB: begin
          instret <= instret + 1'b1;
          if (is_ebreak) begin
            state <= S_HALT;
            halt  <= 1'b1;
          end else begin
            state         <= S_FETCH;
            ifu_req_valid <= 1'b1;
          end
        end
        S_HALT: state <= S_HALT;
        default: begin
          state         <= S_IDLE;
          ifu_req_valid <= 1'b0;
          lsu_req_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Bench for exu_seq_ctrl: reactive bus models feed a program, a scoreboard checks each retirement.
// Also exercises the CTRL_BUS_TIMEOUT_EN build when that macro is defined.
module tb_exu_seq_ctrl;

  localparam logic [7:0] N_ADDI = 8'd1, N_BEQ = 8'd2, N_JAL = 8'd3, N_ADD = 8'd4, N_LUI = 8'd5;
  localparam logic [7:0] N_LW = 8'd20, N_SW = 8'd21, N_EBREAK = 8'd40;
  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;
  localparam logic [2:0] T_BAD = 3'd7;

  typedef struct {
    logic [7:0] num;
    logic [2:0] typ;
    logic       raw;
    int         ird;
    int         lrd;
    logic       norsp_i;
    logic       norsp_l;
  } inst_t;

  typedef struct {
    logic        pc;
    logic        gpr;
    logic        wen;
    int          cycles;
    logic [31:0] instret;
    int          lv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inst_num = '0;
  logic [2:0]  inst_type = '0;
  logic        pc_w_en_raw = 1'b0;
  logic        ifu_req_valid, inst_w_en, lsu_req_valid, lsu_req_wen;
  logic        ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0;
  logic        lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
  logic        pc_w_en, gpr_w_en, halt, illegal, bus_err;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  inst_t prog_q[$];
  exp_t  exp_q[$];

  exu_seq_ctrl #(
    .INST_NUM_WIDTH(8), .INST_TYPE_WIDTH(3), .ISA_WIDTH(32), .TIMEOUT_CYCLES(8),
    .INST_LW(N_LW), .INST_SW(N_SW), .INST_EBREAK(N_EBREAK),
    .TYPE_R(T_R), .TYPE_I(T_I), .TYPE_S(T_S), .TYPE_B(T_B), .TYPE_U(T_U), .TYPE_J(T_J)
  ) dut (
    .clk(clk), .rst(rst), .inst_num(inst_num), .inst_type(inst_type), .pc_w_en_raw(pc_w_en_raw),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid),
    .inst_w_en(inst_w_en), .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_wen(lsu_req_wen), .lsu_rsp_valid(lsu_rsp_valid), .pc_w_en(pc_w_en),
    .gpr_w_en(gpr_w_en), .halt(halt), .illegal(illegal), .bus_err(bus_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic inst_t mk(input logic [7:0] num, input logic [2:0] typ, input logic raw,
                               input int ird, input int lrd);
    inst_t t;
    t.num = num; t.typ = typ; t.raw = raw; t.ird = ird; t.lrd = lrd;
    t.norsp_i = 1'b0; t.norsp_l = 1'b0;
    return t;
  endfunction

  task automatic push_exp(input logic pc, input logic gpr, input logic wen, input int cycles,
                          input logic [31:0] ir, input int lv);
    exp_t e;
    e.pc = pc; e.gpr = gpr; e.wen = wen; e.cycles = cycles; e.instret = ir; e.lv = lv;
    exp_q.push_back(e);
  endtask

  function automatic logic [8:0] outs();
    return {ifu_req_valid, inst_w_en, lsu_req_valid, lsu_req_wen, pc_w_en, gpr_w_en,
            halt, illegal, bus_err};
  endfunction

  // Bus slaves: drive ready after a per-instruction delay, answer one cycle after the handshake.
  initial begin : bus_model
    inst_t cur;
    bit    i_ph = 0, l_ph = 0, have = 0;
    int    icnt = 0, lcnt = 0;
    cur = mk(8'd0, 3'd0, 1'b0, 0, 0);
    forever begin
      @(posedge clk);
      #1;
      ifu_rsp_valid = 1'b0;
      lsu_rsp_valid = 1'b0;
      if (rst) begin
        ifu_req_ready = 1'b0; lsu_req_ready = 1'b0;
        i_ph = 0; l_ph = 0; have = 0; icnt = 0; lcnt = 0;
      end else begin
        if (i_ph) begin
          i_ph = 0;
          ifu_req_ready = 1'b0;
          ifu_rsp_valid = !cur.norsp_i;
          inst_num = cur.num; inst_type = cur.typ; pc_w_en_raw = cur.raw;
        end else if (ifu_req_valid) begin
          if (!have && prog_q.size() > 0) begin
            cur = prog_q.pop_front(); have = 1; icnt = 0;
          end
          if (have) begin
            if (icnt >= cur.ird) begin
              ifu_req_ready = 1'b1; i_ph = 1; have = 0; lcnt = 0;
            end else icnt++;
          end
        end
        if (l_ph) begin
          l_ph = 0;
          lsu_req_ready = 1'b0;
          lsu_rsp_valid = !cur.norsp_l;
        end else if (lsu_req_valid) begin
          if (lcnt >= cur.lrd) begin
            lsu_req_ready = 1'b1; l_ph = 1;
          end else lcnt++;
        end
      end
    end
  end

  // Retirement monitor: a change of instret marks the previous cycle as WB.
  initial begin : monitor
    int cyc = 0, st = 0, iw = 0, pcc = 0, gc = 0, lv = 0;
    bit started = 0, wen_first = 0, wen_stable = 1;
    logic prev_pc = 0, prev_gpr = 0;
    logic [31:0] prev_ir = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; st = 0; iw = 0; pcc = 0; gc = 0; lv = 0;
        started = 0; wen_stable = 1;
      end else begin
        cyc++;
        if (instret !== prev_ir) begin
          if (exp_q.size() == 0) begin
            check("unexpected_retire", instret, prev_ir);
          end else begin
            e = exp_q.pop_front();
            check("wb_pc_w_en", prev_pc, e.pc);
            check("wb_gpr_w_en", prev_gpr, e.gpr);
            check("inst_cycles", cyc - st, e.cycles);
            check("instret", instret, e.instret);
            check("inst_w_en_pulses", iw, 1);
            check("pc_w_en_pulses", pcc, e.pc);
            check("gpr_w_en_pulses", gc, e.gpr);
            check("lsu_valid_cycles", lv, e.lv);
            if (e.lv > 0) begin
              check("lsu_req_wen", wen_first, e.wen);
              check("lsu_wen_stable", wen_stable, 1);
            end
          end
          iw = 0; pcc = 0; gc = 0; lv = 0; started = 0; wen_stable = 1;
        end
        if (ifu_req_valid && !started) begin
          started = 1; st = cyc;
        end
        if (inst_w_en) iw++;
        if (pc_w_en) pcc++;
        if (gpr_w_en) gc++;
        if (lsu_req_valid) begin
          lv++;
          if (lv == 1) wen_first = lsu_req_wen;
          else if (lsu_req_wen !== wen_first) wen_stable = 0;
        end
      end
      prev_pc = pc_w_en; prev_gpr = gpr_w_en; prev_ir = instret;
    end
  end

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 0);
    check("reset_instret", instret, 0);
    prog_q.delete();
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halt; i++) @(negedge clk);
    check("halt_seen", halt, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    inst_t t;
    int    cnt;

    // Zero-wait addi, checked cycle by cycle from reset release.
    do_reset();
    prog_q.push_back(mk(N_ADDI, T_I, 1'b1, 0, 0));
    push_exp(1, 1, 0, 4, 1, 0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      case (k)
        0: check("c0_idle_outs", outs(), 0);
        1: check("c1_ifu_req_valid", ifu_req_valid, 1);
        2: check("c2_inst_w_en", inst_w_en, 1);
        4: check("c4_pc_gpr", {pc_w_en, gpr_w_en}, 2'b11);
        5: check("c5_instret", instret, 1);
        default: ;
      endcase
    end
    wait_drain(20);

    // Memory ops and bus delays.
    do_reset();
    prog_q.push_back(mk(N_SW, T_S, 1'b1, 0, 3));   push_exp(1, 0, 1, 9, 1, 4);
    prog_q.push_back(mk(N_LW, T_I, 1'b1, 0, 0));   push_exp(1, 1, 0, 6, 2, 1);
    prog_q.push_back(mk(N_ADDI, T_I, 1'b1, 2, 0)); push_exp(1, 1, 0, 6, 3, 0);
    prog_q.push_back(mk(N_ADD, T_R, 1'b0, 0, 0));  push_exp(0, 1, 0, 4, 4, 0);
    prog_q.push_back(mk(N_LUI, T_U, 1'b1, 1, 0));  push_exp(1, 1, 0, 5, 5, 0);
    prog_q.push_back(mk(N_LW, T_I, 1'b1, 1, 2));   push_exp(1, 1, 0, 9, 6, 3);
    wait_drain(120);

    // Branch then ebreak: halt, instret frozen, no further fetch.
    do_reset();
    prog_q.push_back(mk(N_BEQ, T_B, 1'b1, 0, 0));    push_exp(1, 0, 0, 4, 1, 0);
    prog_q.push_back(mk(N_EBREAK, T_I, 1'b0, 0, 0)); push_exp(0, 0, 0, 4, 2, 0);
    prog_q.push_back(mk(N_ADDI, T_I, 1'b1, 0, 0));
    wait_halt(40);
    wait_drain(5);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifu_req_valid) cnt++;
    end
    check("halt_no_fetch", cnt, 0);
    check("halt_instret", instret, 2);
    check("halt_flags", {halt, illegal, bus_err}, 3'b100);

    // Illegal type after a jal.
    do_reset();
    prog_q.push_back(mk(N_JAL, T_J, 1'b1, 0, 0)); push_exp(1, 1, 0, 4, 1, 0);
    prog_q.push_back(mk(N_ADDI, T_BAD, 1'b1, 0, 0));
    wait_drain(20);
    cnt = 0;
    for (int i = 0; i < 40 && !halt; i++) begin
      @(negedge clk);
      if (pc_w_en) cnt++;
    end
    check("illegal_halt", halt, 1);
    check("illegal_flag", illegal, 1);
    check("illegal_bus_err", bus_err, 0);
    check("illegal_pc_w_en", cnt, 0);
    check("illegal_instret", instret, 1);

    // Fetch response never arrives.
    do_reset();
    t = mk(N_ADDI, T_I, 1'b1, 0, 0);
    t.norsp_i = 1'b1;
    prog_q.push_back(t);
    for (int i = 0; i < 20 && !ifu_req_valid; i++) @(negedge clk);
    for (int i = 0; i < 20 && ifu_req_valid; i++) @(negedge clk);
    check("fwait_entered", ifu_req_valid, 0);
`ifdef CTRL_BUS_TIMEOUT_EN
    cnt = 0;
    while (!bus_err && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_cycles", cnt, 8);
    check("timeout_flags", {halt, illegal, bus_err}, 3'b101);
    check("timeout_instret", instret, 0);
`else
    repeat (30) @(negedge clk);
    check("no_timeout_flags", {halt, illegal, bus_err}, 3'b000);
    check("no_timeout_ifu_idle", ifu_req_valid, 0);
    check("no_timeout_instret", instret, 0);
`endif

    // Reset while waiting in MWAIT.
    do_reset();
    prog_q.push_back(mk(N_ADDI, T_I, 1'b1, 0, 0)); push_exp(1, 1, 0, 4, 1, 0);
    t = mk(N_LW, T_I, 1'b1, 0, 0);
    t.norsp_l = 1'b1;
    prog_q.push_back(t);
    wait_drain(20);
    for (int i = 0; i < 20 && !lsu_req_valid; i++) @(negedge clk);
    check("mem_entered", lsu_req_valid, 1);
    for (int i = 0; i < 20 && lsu_req_valid; i++) @(negedge clk);
    check("mwait_entered", lsu_req_valid, 0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("mwait_rst_outs", outs(), 0);
    check("mwait_rst_instret", instret, 0);
    prog_q.delete();
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0;
    prog_q.push_back(mk(N_ADDI, T_I, 1'b1, 0, 0)); push_exp(1, 1, 0, 4, 1, 0);
    wait_drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_seq_ctrl.md
# exu_seq_ctrl

Multi-cycle sequencer for the NPC core. It steps each instruction through fetch, execute, optional memory access and writeback. It drives valid/ready handshakes toward the instruction and data buses, and gates the PC, instruction-register and GPR write enables so architectural state changes exactly once per instruction. It sits between the decoder outputs (`inst_num`, `inst_type`), the PC-update unit's raw `pc_w_en` and the bus adapters, and stops the core on `ebreak`, illegal type or bus error.

## Interface
- `INST_NUM_WIDTH`, `INST_TYPE_WIDTH`, `ISA_WIDTH`: from `config.v`; instruction-number, type and data widths.
- `TIMEOUT_CYCLES`, default 255: bus wait limit in cycles. Used only with `CTRL_BUS_TIMEOUT_EN`. Legal range 1..1023.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_num` in `INST_NUM_WIDTH`: decoded instruction number. Valid from EXEC through WB.
- `inst_type` in `INST_TYPE_WIDTH`: decoded type (R/I/S/B/U/J).
- `pc_w_en_raw` in 1: PC write request from the PC-update unit.
- `ifu_req_valid` out 1 / `ifu_req_ready` in 1: fetch request handshake.
- `ifu_rsp_valid` in 1: fetched instruction present on the bus.
- `inst_w_en` out 1: loads the instruction register.
- `lsu_req_valid` out 1 / `lsu_req_ready` in 1: data request handshake.
- `lsu_req_wen` out 1: 1 = store (`sw`), 0 = load (`lw`).
- `lsu_rsp_valid` in 1: load data or store acknowledge.
- `pc_w_en` out 1: gated PC write enable.
- `gpr_w_en` out 1: GPR write enable.
- `halt` out 1: core stopped (sticky).
- `illegal` out 1: stop caused by an unknown `inst_type`.
- `bus_err` out 1: stop caused by a bus timeout.
- `instret` out `ISA_WIDTH`: count of retired instructions; wraps modulo 2^`ISA_WIDTH`.

## Operation
- States: IDLE, FETCH, FWAIT, EXEC, MEM, MWAIT, WB, HALT.
- IDLE → FETCH unconditionally.
- FETCH: `ifu_req_valid`=1. On `ifu_req_ready`=1 → FWAIT.
- FWAIT: on `ifu_rsp_valid` → EXEC, with `inst_w_en`=1 for that cycle.
- EXEC:
  - If `inst_type` is not one of R/I/S/B/U/J → HALT with `illegal`=1.
  - Else if `inst_num` is `lw` or `sw` → MEM.
  - Else → WB.
- MEM: `lsu_req_valid`=1; `lsu_req_wen` = (`inst_num`==`sw`). On `lsu_req_ready` → MWAIT.
- MWAIT: on `lsu_rsp_valid` → WB.
- WB:
  - `pc_w_en` = `pc_w_en_raw`.
  - `gpr_w_en` = 1 for types R/I/U/J, except `ebreak`; 0 for S/B.
  - `instret` increments.
  - Next state: `ebreak` → HALT; otherwise → FETCH.
- HALT: absorbing; `halt`=1. Only `rst` leaves it.
- Outputs are Moore-style from state, except `lsu_req_wen` and the WB enables, which decode the current `inst_num`/`inst_type`.
- `ifu_rsp_valid` and `lsu_rsp_valid` are ignored outside FWAIT/MWAIT. A response arriving in the same cycle as its request handshake is lost; the buses never do this.
- Once raised, a `*_req_valid` stays high until `ready`. Its payload-related outputs stay stable meanwhile.
- `pc_w_en`, `gpr_w_en`, `inst_w_en` are never high outside WB/FWAIT. At most one of each per instruction.

## Timing
- Reset: state IDLE. All outputs 0, including `instret`=0, `halt`/`illegal`/`bus_err`=0.
- With zero-wait buses (ready high, rsp one cycle after handshake):
  - First FETCH is 1 cycle after reset release.
  - Non-memory instruction: 4 cycles (FETCH, FWAIT, EXEC, WB).
  - `lw`/`sw`: 6 cycles.
- Each cycle of ready or rsp delay adds exactly one cycle.
- `instret` updates on the edge ending WB; visible the following cycle.
- `rst` asserted in any state, including mid-handshake or HALT, returns to IDLE on the next edge. Outstanding requests are dropped with no retirement.

## Configuration
- `CTRL_BUS_TIMEOUT_EN` defined:
  - A 10-bit wait counter clears on entry to FETCH/FWAIT/MEM/MWAIT and increments each cycle spent there.
  - When it reaches `TIMEOUT_CYCLES` without the awaited ready/rsp: → HALT with `bus_err`=1.
  - A handshake completing in the same cycle as the limit wins.
- Undefined: no counter; `bus_err` is tied to 0; the controller waits indefinitely.

## Test plan
- Reset, then `addi` with zero-wait buses → `inst_w_en` at cycle 2, `pc_w_en`=`gpr_w_en`=1 at cycle 4, `instret`=1.
- `sw` with `lsu_req_ready` low 3 cycles → `lsu_req_valid` held 4 cycles with `lsu_req_wen`=1, `gpr_w_en`=0 in WB, 9 cycles total.
- `beq` then `ebreak` → `gpr_w_en`=0 in both WBs, `halt`=1 after 2nd WB, `instret`=2 and frozen, no further `ifu_req_valid`.
- `inst_type` outside R..J in EXEC → `halt`=1, `illegal`=1, `instret` unchanged, `pc_w_en` never asserted.
- With `CTRL_BUS_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `ifu_rsp_valid` never arrives → `bus_err`=1 exactly 8 cycles after FWAIT entry. Without the macro → stays in FWAIT, `bus_err`=0.
- `rst` pulsed while in MWAIT → IDLE next cycle, all outputs 0, next fetch starts normally.
